voxel_mem_arbiter: RTL and testbench

Sequences and shares the single-port voxel occupancy RAM between N_REQ ray-traversal read requesters, one scene-loader write port, and a built-in full-volume clear sweep. Converts each request's (x, y, z) into the linear ZYX address, addr = {z, y, x}, and issues at most one RAM access per cycle. Sits between the traversal units and loader on one side and the synchronous voxel RAM (1-cycle read latency) on the other.

---
 rtl/voxel_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_voxel_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voxel_mem_arbiter.sv
// Arbitrates one single-port voxel RAM between N_REQ round-robin readers, a loader
// write port (highest priority) and a full-volume clear sweep; addresses are {z,y,x}.
module voxel_mem_arbiter #(
  parameter int X_BITS    = 5,
  parameter int Y_BITS    = 5,
  parameter int Z_BITS    = 5,
  parameter int N_REQ     = 2,
  parameter int DATA_BITS = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*X_BITS-1:0]       req_x,
  input  logic [N_REQ*Y_BITS-1:0]       req_y,
  input  logic [N_REQ*Z_BITS-1:0]       req_z,
  output logic [N_REQ-1:0]              rsp_valid,
  output logic [DATA_BITS-1:0]          rsp_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [X_BITS-1:0]             wr_x,
  input  logic [Y_BITS-1:0]             wr_y,
  input  logic [Z_BITS-1:0]             wr_z,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          clr_start,
  output logic                          clr_busy,
  output logic                          clr_done,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [X_BITS+Y_BITS+Z_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0]          mem_wdata,
  input  logic [DATA_BITS-1:0]          mem_rdata
);

  localparam int ADDR_BITS = X_BITS + Y_BITS + Z_BITS;
  localparam int PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [ADDR_BITS-1:0]   r_cnt;
  logic [PTR_W-1:0]       r_rr_ptr;
  logic [N_REQ-1:0]       r_rsp_oh;
  logic                   r_clr_done;
  logic [PTR_W-1:0]       w_win;
  logic                   w_found;
  logic                   w_grant;
  logic [ADDR_BITS-1:0]   w_win_addr;

  function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    return PTR_W'(s % N_REQ);
  endfunction

  // Scan starts one past the last winner so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!w_found && req_valid[rr_idx(r_rr_ptr, k)]) begin
        w_found = 1'b1;
        w_win   = rr_idx(r_rr_ptr, k);
      end
    end
  end

  assign w_win_addr = {req_z[w_win*Z_BITS +: Z_BITS],
                       req_y[w_win*Y_BITS +: Y_BITS],
                       req_x[w_win*X_BITS +: X_BITS]};

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    wr_ready  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    w_grant   = 1'b0;
    case (r_state)
      IDLE: begin
        if (clr_start) begin
          w_next = CLEAR;
        end else if (wr_valid) begin
          wr_ready  = 1'b1;
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {wr_z, wr_y, wr_x};
          mem_wdata = wr_data;
        end else if (w_found) begin
          req_ready[w_win] = 1'b1;
          mem_en           = 1'b1;
          mem_addr         = w_win_addr;
          w_grant          = 1'b1;
        end
      end
      CLEAR: begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = r_cnt;
        if (r_cnt == LAST_ADDR) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_rr_ptr   <= PTR_W'(N_REQ - 1);
      r_rsp_oh   <= '0;
      r_clr_done <= 1'b0;
    end else begin
      r_rsp_oh   <= req_ready;
      r_clr_done <= (r_state == CLEAR) && (r_cnt == LAST_ADDR);
      if (w_grant) r_rr_ptr <= w_win;
      if (r_state == IDLE && clr_start) r_cnt <= '0;
      else if (r_state == CLEAR)        r_cnt <= r_cnt + ADDR_BITS'(1);
    end
  end

  assign rsp_valid = r_rsp_oh;
  assign rsp_data  = mem_rdata;
  assign clr_busy  = (r_state == CLEAR);
  assign clr_done  = r_clr_done;

endmodule

// File: tb/tb_voxel_mem_arbiter.sv
// Scoreboard bench for voxel_mem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_voxel_mem_arbiter;
  localparam int XB = 5, YB = 5, ZB = 5, NR = 2, DB = 1;
  localparam int AB = XB + YB + ZB;
  localparam int DEPTH = 1 << AB;

  logic            clk, rst_n;
  logic [NR-1:0]   req_valid, req_ready, rsp_valid;
  logic [NR*XB-1:0] req_x;
  logic [NR*YB-1:0] req_y;
  logic [NR*ZB-1:0] req_z;
  logic [DB-1:0]   rsp_data, wr_data, mem_wdata, mem_rdata;
  logic            wr_valid, wr_ready, clr_start, clr_busy, clr_done, mem_en, mem_we;
  logic [XB-1:0]   wr_x;
  logic [YB-1:0]   wr_y;
  logic [ZB-1:0]   wr_z;
  logic [AB-1:0]   mem_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {int cyc; int idx; logic [DB-1:0] data;} exp_t;
  exp_t q[$];

  logic [DB-1:0] ram [DEPTH] = '{default: '0};
  logic [DB-1:0] shadow [DEPTH];

  voxel_mem_arbiter #(.X_BITS(XB), .Y_BITS(YB), .Z_BITS(ZB), .N_REQ(NR), .DATA_BITS(DB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_z(wr_z), .wr_data(wr_data),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Response monitor: each response must land exactly one cycle after its grant.
  initial forever begin
    @(negedge clk);
    if (q.size() > 0 && q[0].cyc + 1 < cyc) begin
      checks++; errors++;
      $display("FAIL rsp_missing grant_cyc=%0d now=%0d idx=%0d", q[0].cyc, cyc, q[0].idx);
      void'(q.pop_front());
    end
    if (rsp_valid !== '0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected cyc=%0d rsp_valid=%b expected none", cyc, rsp_valid);
      end else begin
        exp_t e;
        logic [NR-1:0] exp_oh;
        e = q.pop_front();
        exp_oh = NR'(1) << e.idx;
        if (e.cyc + 1 != cyc || rsp_valid !== exp_oh || rsp_data !== e.data) begin
          errors++;
          $display("FAIL rsp cyc=%0d rsp_valid=%b rsp_data=%b expected rsp_valid=%b rsp_data=%b at cyc %0d",
                   cyc, rsp_valid, rsp_data, exp_oh, e.data, e.cyc + 1);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({req_ready, wr_ready, rsp_valid, clr_busy, clr_done, mem_en, mem_we} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl got rr=%b wr=%b rv=%b busy=%b done=%b en=%b we=%b expected all 0",
               req_ready, wr_ready, rsp_valid, clr_busy, clr_done, mem_en, mem_we);
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_mem got addr=%h wdata=%b expected 0 0", mem_addr, mem_wdata);
    end
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    req_valid = 2'b11;
    req_x = {5'd4, 5'd1};
    req_y = {5'd5, 5'd2};
    req_z = {5'd6, 5'd3};
    for (int i = 0; i < 4; i++) begin
      int ei;
      logic [AB-1:0] ea;
      ei = i % 2;
      ea = (ei == 1) ? 15'h18A4 : 15'h0C41;
      @(negedge clk);
      checks++;
      if (req_ready !== (NR'(1) << ei) || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== ea) begin
        errors++;
        $display("FAIL rr_grant i=%0d got ready=%b en=%b we=%b addr=%h expected ready=%b en=1 we=0 addr=%h",
                 i, req_ready, mem_en, mem_we, mem_addr, NR'(1) << ei, ea);
      end
      q.push_back('{cyc, ei, shadow[ea]});
      next_cycle();
    end
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b0 || mem_addr !== '0 || req_ready !== '0) begin
      errors++;
      $display("FAIL idle_quiet got en=%b addr=%h ready=%b expected 0 0 0", mem_en, mem_addr, req_ready);
    end
    next_cycle();
  endtask

  task automatic test_write_priority();
    req_valid = 2'b01;
    req_x = {5'd4, 5'd31};
    req_y = {5'd5, 5'd31};
    req_z = {5'd6, 5'd31};
    wr_valid = 1'b1; wr_x = 5'd31; wr_y = 5'd31; wr_z = 5'd31; wr_data = 1'b1;
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'h7FFF ||
        mem_wdata !== 1'b1 || req_ready !== '0) begin
      errors++;
      $display("FAIL wr_priority got wr_ready=%b en=%b we=%b addr=%h wdata=%b ready=%b expected 1 1 1 7fff 1 00",
               wr_ready, mem_en, mem_we, mem_addr, mem_wdata, req_ready);
    end
    shadow[15'h7FFF] = 1'b1;
    next_cycle();
    wr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01 || mem_we !== 1'b0 || mem_addr !== 15'h7FFF || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL read_after_write got ready=%b we=%b addr=%h wr_ready=%b expected 01 0 7fff 0",
               req_ready, mem_we, mem_addr, wr_ready);
    end
    q.push_back('{cyc, 0, shadow[15'h7FFF]});
    next_cycle();
    req_valid = '0;
    next_cycle();
  endtask

  task automatic test_lone_requester();
    req_valid = 2'b10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b10 || mem_addr !== 15'h18A4) begin
        errors++;
        $display("FAIL lone_grant i=%0d got ready=%b addr=%h expected 10 18a4", i, req_ready, mem_addr);
      end
      q.push_back('{cyc, 1, shadow[15'h18A4]});
      next_cycle();
    end
    req_valid = '0;
    next_cycle();
  endtask

  task automatic test_clear_sweep();
    int bad_shown;
    bad_shown = 0;
    req_valid = 2'b01;
    clr_start = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== '0 || mem_en !== 1'b0 || clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_start_cycle got ready=%b en=%b busy=%b expected 00 0 0", req_ready, mem_en, clr_busy);
    end
    next_cycle();
    for (int a = 0; a < DEPTH; a++) shadow[a] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      clr_start = (i == 50);
      wr_valid  = (i == 60);
      @(negedge clk);
      checks++;
      if (clr_busy !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AB'(i) ||
          mem_wdata !== '0 || req_ready !== '0 || wr_ready !== 1'b0 || clr_done !== 1'b0) begin
        errors++;
        if (bad_shown < 10)
          $display("FAIL sweep i=%0d got busy=%b en=%b we=%b addr=%h wdata=%b ready=%b wr_ready=%b done=%b",
                   i, clr_busy, mem_en, mem_we, mem_addr, mem_wdata, req_ready, wr_ready, clr_done);
        bad_shown++;
      end
      next_cycle();
    end
    clr_start = 1'b0;
    wr_valid  = 1'b0;
    @(negedge clk);
    checks++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b1 || req_ready !== 2'b01 || mem_we !== 1'b0 ||
        mem_addr !== 15'h7FFF) begin
      errors++;
      $display("FAIL sweep_end got busy=%b done=%b ready=%b we=%b addr=%h expected 0 1 01 0 7fff",
               clr_busy, clr_done, req_ready, mem_we, mem_addr);
    end
    q.push_back('{cyc, 0, shadow[15'h7FFF]});
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (clr_done !== 1'b0) begin
      errors++;
      $display("FAIL clr_done_pulse got %b expected 0", clr_done);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_sweep();
    clr_start = 1'b1;
    next_cycle();
    clr_start = 1'b0;
    for (int i = 0; i < 100; i++) next_cycle();
    @(negedge clk);
    checks++;
    if (mem_addr !== 15'd100 || clr_busy !== 1'b1) begin
      errors++;
      $display("FAIL sweep_at_100 got addr=%h busy=%b expected 0064 1", mem_addr, clr_busy);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (clr_busy !== 1'b0 || mem_en !== 1'b0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL async_abort got busy=%b en=%b addr=%h expected 0 0 0", clr_busy, mem_en, mem_addr);
    end
    next_cycle();
    rst_n = 1'b1;
    req_valid = 2'b11;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01 || mem_addr !== 15'h7FFF) begin
      errors++;
      $display("FAIL post_reset_grant got ready=%b addr=%h expected 01 7fff", req_ready, mem_addr);
    end
    q.push_back('{cyc, 0, shadow[15'h7FFF]});
    next_cycle();
    req_valid = '0;
    repeat (2) next_cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_x = '0; req_y = '0; req_z = '0;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_z = '0; wr_data = '0;
    clr_start = 1'b0;
    for (int a = 0; a < DEPTH; a++) shadow[a] = '0;
    repeat (2) next_cycle();
    test_reset();
    test_round_robin();
    test_write_priority();
    test_lone_requester();
    test_clear_sweep();
    test_reset_mid_sweep();
    repeat (3) next_cycle();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d outstanding responses expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
